uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter PAYLOAD_BITS, default 8, data bits per frame.
REQ-002 SHALL have parameter STOP_BITS, default 1, stop bits checked per frame (only the first is sampled).
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port uart_rxd  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port uart_rx_en  input  1  receive enable; low holds the FSM in IDLE.
REQ-007 SHALL have port CYCLES_PER_BIT  input  16  bit period minus one, in clk cycles (runtime baud setting).
REQ-008 SHALL have port uart_rx_busy  output  1  high whenever the FSM is not IDLE.
REQ-009 SHALL have port uart_rx_valid  output  1  one-cycle pulse: good frame received.
REQ-010 SHALL have port uart_rx_data  output  PAYLOAD_BITS  last received payload, LSB first on the line.
REQ-011 SHALL have port uart_rx_frame_err  output  1  one-cycle pulse: stop bit sampled low.

Function
REQ-012 uart_rxd SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (rxs) and its 1-cycle-delayed copy.
REQ-013 Bit period SHALL be CYCLES_PER_BIT+1 clocks, which is identical to the transmitter's timing; CYCLES_PER_BIT SHALL be latched into an internal 16-bit register (cpb_q) on start detection and held for the whole frame.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-015 IDLE->START on a falling edge of rxs (previous 1, current 0) while uart_rx_en=1; cycle counter cleared.
REQ-016 START: at counter == cpb_q>>1 (mid start bit), rxs=0 -> DATA with counter cleared; rxs=1 -> IDLE (glitch rejected, no output pulse).
REQ-017 DATA: at counter == cpb_q, sample rxs, shift it into the MSB of the shift register (LSB arrives first), clear the counter, increment the bit counter; after PAYLOAD_BITS samples -> STOP.
REQ-018 STOP: at counter == cpb_q, sample rxs; 1 -> uart_rx_data <= shift register and uart_rx_valid=1 for the next cycle; 0 -> uart_rx_frame_err=1 for the next cycle and uart_rx_data unchanged; then -> IDLE.
REQ-019 The FSM returns to IDLE in mid-stop-bit, which gives half a bit of resync margin for back-to-back frames.
REQ-020 After a frame error the line SHALL be seen high (via the edge rule in REQ-015) before a new start is accepted, so a break condition generates exactly one frame_err.
REQ-021 uart_rx_data SHALL hold its value until the next valid frame.
REQ-022 uart_rx_valid and uart_rx_frame_err SHALL never be high in the same cycle.
REQ-023 Deasserting uart_rx_en mid-frame SHALL NOT abort the frame; the frame completes and IDLE then blocks new starts.
REQ-024 Changing CYCLES_PER_BIT mid-frame SHALL affect only the next frame.
REQ-025 Counters: cycle counter 16 bits, which cannot wrap because it is cleared at cpb_q; bit counter 4 bits.
REQ-026 CYCLES_PER_BIT values below 3 are unsupported and give undefined behaviour.

Reset
REQ-027 While resetn=0 at a clk edge: FSM=IDLE, counters=0, shift register=0, uart_rx_data=0, uart_rx_valid=0, uart_rx_frame_err=0, uart_rx_busy=0, synchronizer flops=1.
REQ-028 Reset asserted mid-frame SHALL discard the frame with no valid or error pulse; after release a fresh falling edge is required.

Structure
REQ-029 FSM state encodings and PAYLOAD_BITS/STOP_BITS defaults SHALL live in a shared uart_pkg package, also used by uart_tx.
REQ-030 The 2-flop synchronizer SHALL be a sub-module named sync_2ff (reset value parameterized); no other sub-modules.

Verification
REQ-031 CYCLES_PER_BIT=103, line driven with 0x55 at 104 clk/bit -> one valid pulse, uart_rx_data=0x55, no frame_err.
REQ-032 Loopback with uart_tx at CYCLES_PER_BIT=103, bytes 0x00, 0xFF, 0xA5 back-to-back -> three valid pulses in order with matching data.
REQ-033 A 40-cycle low glitch on an idle line, CYCLES_PER_BIT=103 -> no valid, no frame_err, busy returns low.
REQ-034 Frame 0x3C with the stop bit held low, then the line held low for 2000 cycles -> exactly one frame_err, uart_rx_data keeps its prior value.
REQ-035 resetn pulsed low during data bit 4 of 0x81, then a clean 0x81 sent -> no pulse for the first frame, valid with 0x81 for the second.
REQ-036 CYCLES_PER_BIT changed from 103 to 51 during data bit 2 -> the current byte decodes correctly at 104 clk/bit, and the next byte at 52 clk/bit decodes correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: state encodings and frame defaults shared by the UART receiver and transmitter.
package uart_pkg;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
   localparam int PAYLOAD_BITS_DEF = 8;
   localparam int STOP_BITS_DEF = 1;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous single-bit input.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic resetn,
   input  logic d_i,
   output logic q_o
);
   logic [1:0] ff_q;
   always_ff @(posedge clk) begin
      if (!resetn) ff_q <= {2{RST_VAL}};
      else ff_q <= {ff_q[0], d_i};
   end
   assign q_o = ff_q[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: mid-bit sampling UART receiver with runtime baud setting.
// Samples are timed from the middle of the start bit, so each decision lands mid-bit.
module uart_rx
   import uart_pkg::*;
#(
   parameter int PAYLOAD_BITS = PAYLOAD_BITS_DEF,
   parameter int STOP_BITS    = STOP_BITS_DEF
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    uart_rxd,
   input  logic                    uart_rx_en,
   input  logic [15:0]             CYCLES_PER_BIT,
   output logic                    uart_rx_busy,
   output logic                    uart_rx_valid,
   output logic [PAYLOAD_BITS-1:0] uart_rx_data,
   output logic                    uart_rx_frame_err
);
   if (STOP_BITS < 1 || PAYLOAD_BITS < 2 || PAYLOAD_BITS > 15) begin : g_bad_params
      $error("uart_rx: unsupported frame parameters");
   end
   uart_state_e state_q, state_d;
   logic rxs, rxs_q;
   logic [2:0] arm_q;
   logic [15:0] cnt_q, cnt_d, cpb_q, cpb_d;
   logic [3:0] bit_q, bit_d;
   logic [PAYLOAD_BITS-1:0] sr_q, sr_d, data_q, data_d;
   logic valid_q, valid_d, err_q, err_d;
   sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .resetn(resetn), .d_i(uart_rxd), .q_o(rxs));
   // Starts are ignored until the synchronizer's reset ones have flushed, so a low line at release is no edge.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         rxs_q   <= 1'b1;
         arm_q   <= '0;
         cnt_q   <= '0;
         cpb_q   <= '0;
         bit_q   <= '0;
         sr_q    <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rxs_q   <= rxs;
         arm_q   <= {arm_q[1:0], 1'b1};
         cnt_q   <= cnt_d;
         cpb_q   <= cpb_d;
         bit_q   <= bit_d;
         sr_q    <= sr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 16'd1;
      cpb_d   = cpb_q;
      bit_d   = bit_q;
      sr_d    = sr_q;
      data_d  = data_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            if (uart_rx_en && arm_q[2] && rxs_q && !rxs) begin
               state_d = START;
               cpb_d   = CYCLES_PER_BIT;
            end
         end
         START: if (cnt_q == (cpb_q >> 1)) begin
            cnt_d   = '0;
            state_d = rxs ? IDLE : DATA;
         end
         DATA: if (cnt_q == cpb_q) begin
            cnt_d = '0;
            sr_d  = {rxs, sr_q[PAYLOAD_BITS-1:1]};
            bit_d = bit_q + 4'd1;
            if (bit_q == 4'(PAYLOAD_BITS - 1)) state_d = STOP;
         end
         STOP: if (cnt_q == cpb_q) begin
            cnt_d   = '0;
            state_d = IDLE;
            valid_d = rxs;
            err_d   = !rxs;
            data_d  = rxs ? sr_q : data_q;
         end
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      uart_rx_busy      = state_q != IDLE;
      uart_rx_valid     = valid_q;
      uart_rx_frame_err = err_q;
      uart_rx_data      = data_q;
   end
endmodule
